// File: rtl/ebi_bus_arb.sv
// Two-master arbiter/sequencer for the internal EBI register bus.
// One transaction at a time: grant, single strobe, optional read wait, ack.
module ebi_bus_arb #(
    parameter int U_DLY     = 1,
    parameter int RD_LAT    = 2,
    parameter int PRIO_MODE = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [15:0] m0_addr,
    input  logic [7:0]  m0_wdata,
    output logic        m0_ack,
    output logic [7:0]  m0_rdata,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [15:0] m1_addr,
    input  logic [7:0]  m1_wdata,
    output logic        m1_ack,
    output logic [7:0]  m1_rdata,
    output logic [15:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        bus_oe,
    input  logic [7:0]  bus_rdata,
    output logic        arb_busy,
    output logic        arb_gnt
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [3:0] RD_LAT_M1 = 4'(RD_LAT - 1);

    // U_DLY is kept for parameter compatibility; the synthesizable flops carry no delay.
    logic unused_u_dly;
    assign unused_u_dly = (U_DLY != 0);

    logic [1:0]  state_q, state_d;
    logic        last_gnt_q, last_gnt_d;
    logic        gnt_q, gnt_d;
    logic [15:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  m0_rdata_q, m0_rdata_d;
    logic [7:0]  m1_rdata_q, m1_rdata_d;
    logic        winner;

    // Contention goes to the master not served last, or to m0 in fixed-priority mode.
    always_comb begin
        if (m0_req && m1_req) begin
            winner = (PRIO_MODE != 0) ? 1'b0 : ~last_gnt_q;
        end else begin
            winner = m1_req;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        gnt_d      = gnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    gnt_d      = winner;
                    last_gnt_d = winner;
                    addr_d     = winner ? m1_addr  : m0_addr;
                    wdata_d    = winner ? m1_wdata : m0_wdata;
                    wr_d       = winner ? m1_wr    : m0_wr;
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (wr_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = RD_LAT_M1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (gnt_q) begin
                        m1_rdata_d = bus_rdata;
                    end else begin
                        m0_rdata_d = bus_rdata;
                    end
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            last_gnt_q <= 1'b1;
            gnt_q      <= 1'b0;
            addr_q     <= 16'h0000;
            wdata_q    <= 8'h00;
            wr_q       <= 1'b0;
            cnt_q      <= 4'd0;
            m0_rdata_q <= 8'h00;
            m1_rdata_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    assign bus_we    = (state_q == S_ISSUE) &&  wr_q;
    assign bus_oe    = (state_q == S_ISSUE) && !wr_q;
    assign m0_ack    = (state_q == S_DONE)  && !gnt_q;
    assign m1_ack    = (state_q == S_DONE)  &&  gnt_q;
    assign arb_busy  = (state_q != S_IDLE);
    assign arb_gnt   = gnt_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_ebi_bus_arb.sv
// Directed bench for ebi_bus_arb: table of single transactions plus hand-written
// contention and reset-abort sequences; dut1 is the fixed-priority variant.
module tb_ebi_bus_arb;

    localparam int RD_LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m0_req = 1'b0, m0_wr = 1'b0, m1_req = 1'b0, m1_wr = 1'b0;
    logic [15:0] m0_addr = '0, m1_addr = '0;
    logic [7:0]  m0_wdata = '0, m1_wdata = '0;
    logic [7:0]  bus_rdata = 8'hEE;

    logic        d0_m0_ack, d0_m1_ack, d0_we, d0_oe, d0_busy, d0_gnt;
    logic [7:0]  d0_m0_rdata, d0_m1_rdata, d0_wdata;
    logic [15:0] d0_addr;
    logic        d1_m0_ack, d1_m1_ack, d1_we, d1_oe, d1_busy, d1_gnt;
    logic [7:0]  d1_m0_rdata, d1_m1_rdata, d1_wdata;
    logic [15:0] d1_addr;

    int errors = 0;
    int checks = 0;
    int d0_strobes = 0;
    int d1_strobes = 0;

    typedef struct {
        bit          mst;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        bit          drop_early;
        int          exp_ack;
        logic [7:0]  exp_rdata;
        logic [7:0]  exp_other;
    } vec_t;

    vec_t vecs [7];

    ebi_bus_arb #(.U_DLY(1), .RD_LAT(RD_LAT), .PRIO_MODE(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(d0_m0_ack), .m0_rdata(d0_m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(d0_m1_ack), .m1_rdata(d0_m1_rdata),
        .bus_addr(d0_addr), .bus_wdata(d0_wdata), .bus_we(d0_we), .bus_oe(d0_oe),
        .bus_rdata(bus_rdata), .arb_busy(d0_busy), .arb_gnt(d0_gnt)
    );

    ebi_bus_arb #(.U_DLY(1), .RD_LAT(RD_LAT), .PRIO_MODE(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(d1_m0_ack), .m0_rdata(d1_m0_rdata),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(d1_m1_ack), .m1_rdata(d1_m1_rdata),
        .bus_addr(d1_addr), .bus_wdata(d1_wdata), .bus_we(d1_we), .bus_oe(d1_oe),
        .bus_rdata(bus_rdata), .arb_busy(d1_busy), .arb_gnt(d1_gnt)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Strobe exclusivity, busy during strobes/acks, and at most one strobe per ack.
    always @(negedge clk) begin
        if (!rst_n) begin
            d0_strobes <= 0;
            d1_strobes <= 0;
        end else begin
            if (d0_we || d0_oe) begin
                check_output("d0 we/oe exclusive", 64'(d0_we & d0_oe), 64'd0);
                check_output("d0 busy at strobe", 64'(d0_busy), 64'd1);
                check_output("d0 strobes before ack", 64'(d0_strobes), 64'd0);
            end
            if (d1_we || d1_oe) begin
                check_output("d1 we/oe exclusive", 64'(d1_we & d1_oe), 64'd0);
                check_output("d1 strobes before ack", 64'(d1_strobes), 64'd0);
            end
            if (d0_m0_ack || d0_m1_ack) check_output("d0 busy at ack", 64'(d0_busy), 64'd1);
            d0_strobes <= (d0_m0_ack || d0_m1_ack) ? 0 : d0_strobes + int'(d0_we || d0_oe);
            d1_strobes <= (d1_m0_ack || d1_m1_ack) ? 0 : d1_strobes + int'(d1_we || d1_oe);
        end
    end

    function automatic logic [63:0] d0_outs();
        return 64'({d0_m0_ack, d0_m0_rdata, d0_m1_ack, d0_m1_rdata, d0_addr, d0_wdata,
                    d0_we, d0_oe, d0_busy, d0_gnt});
    endfunction

    function automatic logic [63:0] d1_outs();
        return 64'({d1_m0_ack, d1_m0_rdata, d1_m1_ack, d1_m1_rdata, d1_addr, d1_wdata,
                    d1_we, d1_oe, d1_busy, d1_gnt});
    endfunction

    task automatic drive_req(input bit mst, input bit val);
        if (mst) m1_req = val;
        else     m0_req = val;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 1'b0;
        m1_req = 1'b0;
        bus_rdata = 8'hEE;
        repeat (2) @(negedge clk);
        check_output("reset outputs dut0", d0_outs(), 64'd0);
        check_output("reset outputs dut1", d1_outs(), 64'd0);
        rst_n = 1'b1;
    endtask

    // One transaction from an IDLE negedge; ends on an IDLE negedge.
    task automatic apply_stimulus(input vec_t v, input int idx);
        int ack_cyc = -1, acks = 0, other_acks = 0, we_n = 0, oe_n = 0, strobe_cyc = -1;
        logic [15:0] s_addr = '0;
        logic [7:0]  s_wdata = '0;
        logic busy1 = 1'b0, idle_busy = 1'b1;
        string tag;
        tag = $sformatf("vec%0d", idx);
        if (v.mst) begin
            m1_wr = v.wr; m1_addr = v.addr; m1_wdata = v.wdata;
        end else begin
            m0_wr = v.wr; m0_addr = v.addr; m0_wdata = v.wdata;
        end
        drive_req(v.mst, 1'b1);
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            bus_rdata = (c == 1 + RD_LAT) ? v.rdata : 8'hEE;
            if (d0_we || d0_oe) begin
                strobe_cyc = c;
                s_addr = d0_addr;
                s_wdata = d0_wdata;
            end
            we_n += int'(d0_we);
            oe_n += int'(d0_oe);
            if (c == 1) busy1 = d0_busy;
            if (ack_cyc > 0 && c == ack_cyc + 1) idle_busy = d0_busy;
            if (v.mst ? d0_m1_ack : d0_m0_ack) begin
                acks++;
                if (ack_cyc < 0) ack_cyc = c;
                drive_req(v.mst, 1'b0);
            end
            if (v.mst ? d0_m0_ack : d0_m1_ack) other_acks++;
            if (c == 1 && v.drop_early) drive_req(v.mst, 1'b0);
            if (ack_cyc > 0 && c == ack_cyc + 3) break;
        end
        drive_req(v.mst, 1'b0);
        bus_rdata = 8'hEE;
        check_output({tag, " strobe cycle"}, 64'(strobe_cyc), 64'd1);
        check_output({tag, " we count"}, 64'(we_n), 64'(v.wr));
        check_output({tag, " oe count"}, 64'(oe_n), 64'(!v.wr));
        check_output({tag, " bus_addr"}, 64'(s_addr), 64'(v.addr));
        check_output({tag, " bus_wdata"}, 64'(s_wdata), 64'(v.wdata));
        check_output({tag, " busy in issue"}, 64'(busy1), 64'd1);
        check_output({tag, " ack cycle"}, 64'(ack_cyc), 64'(v.exp_ack));
        check_output({tag, " ack count"}, 64'(acks), 64'd1);
        check_output({tag, " other ack"}, 64'(other_acks), 64'd0);
        check_output({tag, " busy after ack"}, 64'(idle_busy), 64'd0);
        check_output({tag, " arb_gnt"}, 64'(d0_gnt), 64'(v.mst));
        check_output({tag, " rdata"}, 64'(v.mst ? d0_m1_rdata : d0_m0_rdata), 64'(v.exp_rdata));
        check_output({tag, " other rdata"}, 64'(v.mst ? d0_m0_rdata : d0_m1_rdata), 64'(v.exp_other));
    endtask

    // Both masters request four writes each; record the order of acks.
    task automatic grant_sequence(input bit sel, input bit prio);
        int n0 = 0, n1 = 0, total = 0, last_c = -1;
        bit got [8];
        bit a0, a1, exp_g;
        m0_wr = 1'b1; m0_addr = 16'h0100; m0_wdata = 8'h10;
        m1_wr = 1'b1; m1_addr = 16'h0200; m1_wdata = 8'h20;
        m0_req = 1'b1;
        m1_req = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            a0 = sel ? d1_m0_ack : d0_m0_ack;
            a1 = sel ? d1_m1_ack : d0_m1_ack;
            if (a0 && total < 8) begin
                got[total] = 1'b0; total++; n0++; last_c = c;
                if (n0 == 4) m0_req = 1'b0;
            end
            if (a1 && total < 8) begin
                got[total] = 1'b1; total++; n1++; last_c = c;
                if (n1 == 4) m1_req = 1'b0;
            end
            if (total == 8) break;
        end
        m0_req = 1'b0;
        m1_req = 1'b0;
        check_output($sformatf("prio%0d ack total", prio), 64'(total), 64'd8);
        check_output($sformatf("prio%0d last ack cycle", prio), 64'(last_c), 64'd23);
        for (int i = 0; i < total; i++) begin
            exp_g = prio ? (i >= 4) : i[0];
            check_output($sformatf("prio%0d grant %0d", prio, i), 64'(got[i]), 64'(exp_g));
        end
        @(negedge clk);
    endtask

    initial begin
        int acks_after, strobes_after, busy_after;
        vecs[0] = '{1'b0, 1'b1, 16'h0012, 8'hA5, 8'h00, 1'b0, 2,          8'h00, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 16'hE000, 8'h00, 8'h3C, 1'b0, 2 + RD_LAT, 8'h3C, 8'h00};
        vecs[2] = '{1'b0, 1'b0, 16'h1234, 8'h11, 8'h5A, 1'b1, 2 + RD_LAT, 8'h5A, 8'h3C};
        vecs[3] = '{1'b1, 1'b1, 16'hBEEF, 8'h77, 8'h00, 1'b0, 2,          8'h3C, 8'h5A};
        vecs[4] = '{1'b0, 1'b0, 16'h00FF, 8'h00, 8'hC3, 1'b0, 2 + RD_LAT, 8'hC3, 8'h3C};
        vecs[5] = '{1'b1, 1'b0, 16'hFFFF, 8'h99, 8'h81, 1'b0, 2 + RD_LAT, 8'h81, 8'hC3};
        vecs[6] = '{1'b0, 1'b1, 16'h0012, 8'hA5, 8'h00, 1'b0, 2,          8'h00, 8'h00};

        #2;
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 6; i++) apply_stimulus(vecs[i], i);

        grant_sequence(1'b0, 1'b0);
        do_reset();
        @(negedge clk);
        grant_sequence(1'b1, 1'b1);

        m1_wr = 1'b0; m1_addr = 16'hE000; m1_wdata = 8'h00;
        m1_req = 1'b1;
        repeat (2) @(negedge clk);
        check_output("abort busy in wait", 64'(d0_busy), 64'd1);
        rst_n = 1'b0;
        m1_req = 1'b0;
        #1;
        check_output("abort outputs dut0", d0_outs(), 64'd0);
        check_output("abort outputs dut1", d1_outs(), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        acks_after = 0; strobes_after = 0; busy_after = 0;
        repeat (6) begin
            @(negedge clk);
            bus_rdata = 8'h3C;
            acks_after += int'(d0_m1_ack);
            strobes_after += int'(d0_we || d0_oe);
            busy_after += int'(d0_busy);
        end
        bus_rdata = 8'hEE;
        check_output("abort no m1_ack", 64'(acks_after), 64'd0);
        check_output("abort no strobes", 64'(strobes_after), 64'd0);
        check_output("abort stays idle", 64'(busy_after), 64'd0);
        apply_stimulus(vecs[6], 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
